// File: rtl/tc_sram_arbiter.sv
// tc_sram_arbiter: round-robin share of one tc_sram port.
// Ports: clk_i/rst_ni (sync, active-low); per-requester req/gnt,
//   we/addr/wdata/be, rvalid, shared rdata; one SRAM port
//   (sram_req/we/addr/wdata/be, sram_rdata); idle_o.
module tc_sram_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned NoWords   = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth =
    (NoWords > 1) ? $clog2(NoWords) : 1,
  parameter int unsigned BeWidth   =
    (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_i,
  output logic [NumReq-1:0]                  gnt_o,
  input  logic [NumReq-1:0]                  we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]                  rvalid_o,
  output logic [DataWidth-1:0]               rdata_o,
  output logic                               sram_req_o,
  output logic                               sram_we_o,
  output logic [AddrWidth-1:0]               sram_addr_o,
  output logic [DataWidth-1:0]               sram_wdata_o,
  output logic [BeWidth-1:0]                 sram_be_o,
  input  logic [DataWidth-1:0]               sram_rdata_i,
  output logic                               idle_o
);

  localparam int unsigned IdxWidth =
    (NumReq > 1) ? $clog2(NumReq) : 1;

  if (Latency < 1 || Latency > 8) begin : g_bad_latency
    $error("tc_sram_arbiter: Latency must be 1..8");
  end

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [IdxWidth-1:0] idx;
  } stage_t;

  logic [IdxWidth-1:0]  rr_q;
  logic [IdxWidth-1:0]  rr_nxt;
  logic [IdxWidth-1:0]  win;
  logic                 found;
  logic                 gnt_v;
  stage_t               s0;
  stage_t [Latency-1:0] pipe_q;
  stage_t [Latency-1:0] pipe_d;
  stage_t               last;
  logic [Latency-1:0]   vld;

  // Search from the pointer, wrapping modulo NumReq.
  always_comb begin
    logic [IdxWidth-1:0] c;
    win   = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      c = IdxWidth'((32'(rr_q) + k) % NumReq);
      if (!found && req_i[c]) begin
        found = 1'b1;
        win   = c;
      end
    end
  end

  // Requests are ignored while reset is held.
  assign gnt_v  = found & rst_ni;
  assign rr_nxt = IdxWidth'((32'(win) + 1) % NumReq);

  always_comb begin
    gnt_o        = '0;
    sram_req_o   = gnt_v;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_v) begin
      gnt_o[win]   = 1'b1;
      sram_we_o    = we_i[win];
      sram_addr_o  = addr_i[win];
      sram_wdata_o = wdata_i[win];
      sram_be_o    = be_i[win];
    end
  end

  assign s0.valid = sram_req_o;
  assign s0.we    = sram_we_o;
  assign s0.idx   = win;

  if (Latency > 1) begin : g_shift
    assign pipe_d = {pipe_q[Latency-2:0], s0};
  end else begin : g_one
    assign pipe_d = s0;
  end

  for (genvar g = 0; g < Latency; g++) begin : g_vld
    assign vld[g] = pipe_q[g].valid;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      pipe_q <= '0;
    end else begin
      if (gnt_v) rr_q <= rr_nxt;
      pipe_q <= pipe_d;
    end
  end

  assign last = pipe_q[Latency-1];

  // Stage contents left over from before reset must not leak out.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (rst_ni && last.valid) begin
      rvalid_o[last.idx] = 1'b1;
      if (!last.we) rdata_o = sram_rdata_i;
    end
  end

  assign idle_o = !sram_req_o && (!rst_ni || !(|vld));

endmodule

// File: tb/tb_tc_sram_arbiter.sv
// tb_tc_sram_arbiter: scoreboard bench for tc_sram_arbiter.
// NumReq=4, Latency=3, behavioural SRAM attached.
module tb_tc_sram_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned L  = 3;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, gnt, we, rvalid;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0][BW-1:0] be;
  logic [DW-1:0] rdata, s_wdata, s_rdata;
  logic s_req, s_we, idle;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;

  always #5 clk = ~clk;

  tc_sram_arbiter #(
    .NumReq(N), .NoWords(1024), .DataWidth(DW),
    .ByteWidth(8), .Latency(L)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_req_o(s_req), .sram_we_o(s_we),
    .sram_addr_o(s_addr), .sram_wdata_o(s_wdata),
    .sram_be_o(s_be), .sram_rdata_i(s_rdata),
    .idle_o(idle)
  );

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_q [L];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      for (int i = 0; i < L; i++) rd_q[i] <= '0;
    end else begin
      if (s_req) begin
        if (s_we) begin
          for (int b = 0; b < BW; b++)
            if (s_be[b]) mem[s_addr][8*b+:8] <= s_wdata[8*b+:8];
        end else begin
          rd_q[0] <= mem[s_addr];
        end
      end
      for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
    end
  end
  assign s_rdata = rd_q[L-1];

  typedef struct {
    int unsigned   idx;
    logic          we;
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [1024];
  int unsigned   rr;
  int unsigned   cyc;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic w,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [BW-1:0] m);
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    be[i]    = m;
  endtask

  task automatic tick(input logic rst, input logic [N-1:0] r);
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [DW-1:0] erd;
    int unsigned   w;
    int unsigned   c;
    bit            found;
    exp_t          e;
    logic [AW-1:0] a;
    rst_n = rst;
    req   = r;
    @(negedge clk);
    eg = '0; w = 0; found = 0;
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        c = (rr + k) % N;
        if (!found && r[c[1:0]]) begin
          found = 1;
          w     = c;
        end
      end
    end
    if (found) eg[w[1:0]] = 1'b1;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("sram_req", 64'(s_req), 64'(found));
    chk("idle", 64'(idle),
        64'(!found && (!rst || q.size() == 0)));
    erv = '0; erd = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (rst) begin
        erv[e.idx[1:0]] = 1'b1;
        if (!e.we) erd = e.data;
      end
    end
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("rdata", rdata, erd);
    if (found) begin
      a = addr[w[1:0]];
      chk("sram_addr", 64'(s_addr), 64'(a));
      chk("sram_we", 64'(s_we), 64'(we[w[1:0]]));
      if (we[w[1:0]]) begin
        chk("sram_wdata", s_wdata, wdata[w[1:0]]);
        chk("sram_be", 64'(s_be), 64'(be[w[1:0]]));
      end
      e.idx  = w;
      e.we   = we[w[1:0]];
      e.data = ref_mem[a];
      e.due  = cyc + L;
      q.push_back(e);
      if (we[w[1:0]])
        for (int b = 0; b < BW; b++)
          if (be[w[1:0]][b])
            ref_mem[a][8*b+:8] = wdata[w[1:0]][8*b+:8];
      rr = (w + 1) % N;
    end else begin
      chk("sram_addr_idle", 64'(s_addr), 64'd0);
    end
    if (!rst) begin
      q.delete();
      rr = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick(1'b1, '0);
  endtask

  initial begin
    checks = 0; failures = 0; rr = 0; cyc = 0;
    rst_n = 1'b0; req = '0; we = '0;
    addr = '0; wdata = '0; be = '0;
    @(posedge clk);
    #1;
    tick(1'b0, '0);
    tick(1'b0, 4'hF);

    set_op(0, 1'b1, 10'h10, 64'hDEADBEEF_01234567, 8'hFF);
    tick(1'b1, 4'b0001);
    set_op(0, 1'b0, 10'h10, '0, '0);
    tick(1'b1, 4'b0001);
    idle_cycles(L + 1);

    set_op(0, 1'b1, 10'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick(1'b1, 4'b0001);
    set_op(0, 1'b1, 10'h20, 64'h0, 8'h0F);
    tick(1'b1, 4'b0001);
    set_op(0, 1'b0, 10'h20, '0, '0);
    tick(1'b1, 4'b0001);
    idle_cycles(L + 1);

    tick(1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++)
        set_op(i, c < 4, AW'(10'h100 + i),
               {16'(i + 1), 16'hA5A5, 16'(c), 16'h5A5A}, 8'hFF);
      tick(1'b1, 4'hF);
    end
    idle_cycles(L + 1);

    set_op(1, 1'b0, 10'h101, '0, '0);
    tick(1'b1, 4'b0010);
    set_op(0, 1'b0, 10'h100, '0, '0);
    repeat (3) tick(1'b1, 4'b0011);
    idle_cycles(L + 1);

    set_op(0, 1'b1, 10'h30, 64'h1111_2222_3333_4444, 8'hFF);
    tick(1'b1, 4'b0001);
    set_op(0, 1'b1, 10'h31, 64'h5555_6666_7777_8888, 8'hFF);
    tick(1'b1, 4'b0001);
    set_op(0, 1'b1, 10'h32, 64'h9999_AAAA_BBBB_CCCC, 8'hFF);
    tick(1'b1, 4'b0001);
    set_op(1, 1'b0, 10'h30, '0, '0);
    set_op(3, 1'b0, 10'h31, '0, '0);
    set_op(2, 1'b0, 10'h32, '0, '0);
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b0100);
    idle_cycles(L + 2);

    set_op(0, 1'b0, 10'h30, '0, '0);
    tick(1'b1, 4'b0001);
    tick(1'b0, 4'hF);
    tick(1'b0, 4'hF);
    set_op(2, 1'b1, 10'h50, 64'hCAFE_F00D_1234_5678, 8'hFF);
    set_op(3, 1'b0, 10'h50, '0, '0);
    tick(1'b1, 4'b1100);
    tick(1'b1, 4'b1000);
    idle_cycles(L + 2);

    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        set_op(i, 1'($urandom_range(0, 1)),
               AW'(10'h40 + $urandom_range(0, 7)),
               {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      tick(1'b1, 4'($urandom_range(0, 15)));
    end
    idle_cycles(L + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
